// File: rtl/elevator_pkg.sv
// elevator_pkg
// Shared types and constants for the elevator car controller.
//   state_e  : car FSM states (IDLE / MOVE / DOOR)
//   dir_e    : committed travel direction (NONE / UP / DOWN)
//   FLOOR_W  : width of floor numbers (floors are numbered from 1)
//   floor_in_range() : true for a floor number the building actually has
package elevator_pkg;

   localparam int FLOOR_W        = 3;
   localparam int NUM_FLOORS_DEF = 5;
   localparam int MOVE_TICKS_DEF = 2;
   localparam int DOOR_TICKS_DEF = 3;

   localparam logic [FLOOR_W-1:0] FLOOR_MIN = FLOOR_W'(1);

   typedef enum logic [1:0] {
      IDLE,
      MOVE,
      DOOR
   } state_e;

   typedef enum logic [1:0] {
      NONE,
      UP,
      DOWN
   } dir_e;

   // Floor 0 and anything above the top floor do not exist.
   function automatic logic floor_in_range(input logic [FLOOR_W-1:0] f,
                                           input int num_floors);
      return (f >= FLOOR_MIN) && (int'(f) <= num_floors);
   endfunction

endpackage

// File: rtl/elevator_req_tracker.sv
// elevator_req_tracker
// Holds the pending-floor bitmap for the car controller.
// Ports:
//   clk, rst              : clock, asynchronous active-low reset
//   req_valid, req_floor  : decoded keypad request (one-cycle strobe)
//   cur_floor             : current car floor
//   in_move               : car is in MOVE (a request for the floor it is leaving is kept)
//   clr_en, clr_floor     : serve (clear) one floor this cycle
//   req_ok                : request strobe carries a floor that exists
//   req_here              : valid request for the current floor
//   pending               : bit f-1 set = floor f requested (registered)
//   any_above, any_below  : some pending floor lies above / below cur_floor
module elevator_req_tracker
   import elevator_pkg::*;
#(
   parameter int NUM_FLOORS = NUM_FLOORS_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   input  logic [FLOOR_W-1:0]    req_floor,
   input  logic [FLOOR_W-1:0]    cur_floor,
   input  logic                  in_move,
   input  logic                  clr_en,
   input  logic [FLOOR_W-1:0]    clr_floor,
   output logic                  req_ok,
   output logic                  req_here,
   output logic [NUM_FLOORS-1:0] pending,
   output logic                  any_above,
   output logic                  any_below
);

   logic [NUM_FLOORS-1:0] pending_q;
   logic [NUM_FLOORS-1:0] pending_d;
   logic [NUM_FLOORS-1:0] set_mask;
   logic [NUM_FLOORS-1:0] clr_mask;

   // A request for the floor the car is standing at is served by the door
   // instead of being remembered, unless the car is already leaving it.
   // Clear is applied after set so an arrival always wins over a
   // simultaneous request for the same floor.
   always_comb begin
      req_ok    = req_valid && floor_in_range(req_floor, NUM_FLOORS);
      req_here  = req_ok && (req_floor == cur_floor);
      set_mask  = '0;
      clr_mask  = '0;
      any_above = 1'b0;
      any_below = 1'b0;
      for (int f = 1; f <= NUM_FLOORS; f++) begin
         if (req_ok && (req_floor == FLOOR_W'(f)) && (!req_here || in_move))
            set_mask[f-1] = 1'b1;
         if (clr_en && (clr_floor == FLOOR_W'(f)))
            clr_mask[f-1] = 1'b1;
         if (pending_q[f-1] && (FLOOR_W'(f) > cur_floor))
            any_above = 1'b1;
         if (pending_q[f-1] && (FLOOR_W'(f) < cur_floor))
            any_below = 1'b1;
      end
      pending_d = (pending_q | set_mask) & ~clr_mask;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         pending_q <= '0;
      else
         pending_q <= pending_d;
   end

   assign pending = pending_q;

endmodule

// File: rtl/elevator_car_ctrl.sv
// elevator_car_ctrl
// SCAN (collective) car controller for a small elevator. Requests are held
// in elevator_req_tracker; this module owns the car FSM, the step_tick
// counter used for both travel and door dwell, and the floor/direction
// registers.
// Ports:
//   clk, rst              : clock, asynchronous active-low reset
//   req_valid, req_floor  : keypad request strobe and floor (1..NUM_FLOORS)
//   step_tick             : one-cycle timing enable from the divider chain
//   cur_floor             : current floor (resets to 1)
//   dir_up, dir_down      : car committed up / down (only while moving)
//   moving, door_open     : car is travelling / door is open
//   pending               : requested-floor bitmap
// All outputs come straight from flops.
module elevator_car_ctrl
   import elevator_pkg::*;
#(
   parameter int NUM_FLOORS = NUM_FLOORS_DEF,
   parameter int MOVE_TICKS = MOVE_TICKS_DEF,
   parameter int DOOR_TICKS = DOOR_TICKS_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   input  logic [FLOOR_W-1:0]    req_floor,
   input  logic                  step_tick,
   output logic [FLOOR_W-1:0]    cur_floor,
   output logic                  dir_up,
   output logic                  dir_down,
   output logic                  moving,
   output logic                  door_open,
   output logic [NUM_FLOORS-1:0] pending
);

   localparam int MAX_TICKS = (MOVE_TICKS > DOOR_TICKS) ? MOVE_TICKS : DOOR_TICKS;
   localparam int CNT_W     = $clog2(MAX_TICKS + 1);

   localparam logic [CNT_W-1:0]   MOVE_LAST = CNT_W'(MOVE_TICKS - 1);
   localparam logic [CNT_W-1:0]   DOOR_LAST = CNT_W'(DOOR_TICKS - 1);
   localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(NUM_FLOORS);

   state_e               state_q, state_d;
   dir_e                 dir_q, dir_d;
   logic [FLOOR_W-1:0]   floor_q, floor_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 dir_up_q, dir_down_q, moving_q, door_open_q;

   logic [FLOOR_W-1:0]   floor_next;
   logic                 next_pending;
   logic                 clr_en;
   logic [FLOOR_W-1:0]   clr_floor;
   logic                 req_ok, req_here, any_above, any_below;
   logic [NUM_FLOORS-1:0] pending_w;

   elevator_req_tracker #(
      .NUM_FLOORS (NUM_FLOORS)
   ) u_req_tracker (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_floor (req_floor),
      .cur_floor (floor_q),
      .in_move   (state_q == MOVE),
      .clr_en    (clr_en),
      .clr_floor (clr_floor),
      .req_ok    (req_ok),
      .req_here  (req_here),
      .pending   (pending_w),
      .any_above (any_above),
      .any_below (any_below)
   );

   // Next-state logic. The single counter times travel in MOVE and dwell in
   // DOOR; it is cleared whenever a state is entered, so a tick in the cycle
   // that makes the transition is never counted.
   always_comb begin
      state_d      = state_q;
      dir_d        = dir_q;
      floor_d      = floor_q;
      cnt_d        = cnt_q;
      clr_en       = 1'b0;
      clr_floor    = floor_q;
      floor_next   = (dir_q == DOWN) ? (floor_q - 1'b1) : (floor_q + 1'b1);
      next_pending = 1'b0;
      for (int f = 1; f <= NUM_FLOORS; f++) begin
         if (floor_next == FLOOR_W'(f))
            next_pending = pending_w[f-1];
      end

      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (req_here) begin
               state_d = DOOR;
            end else if (pending_w == '0) begin
               dir_d = NONE;
            end else if (any_above || any_below) begin
               // SCAN: keep going the same way while there is work that way.
               state_d = MOVE;
               unique case (dir_q)
                  UP:      dir_d = any_above ? UP : DOWN;
                  DOWN:    dir_d = any_below ? DOWN : UP;
                  default: dir_d = any_above ? UP : DOWN;
               endcase
            end else begin
               // Only the current floor is pending: serve it with the door.
               state_d = DOOR;
               clr_en  = 1'b1;
            end
         end

         MOVE: begin
            if (step_tick) begin
               if (cnt_q == MOVE_LAST) begin
                  cnt_d   = '0;
                  floor_d = floor_next;
                  // A request arriving together with the arrival is served too.
                  if (next_pending || (req_ok && (req_floor == floor_next))) begin
                     state_d   = DOOR;
                     clr_en    = 1'b1;
                     clr_floor = floor_next;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end

         DOOR: begin
            // Pressing the button for this floor again keeps the door open.
            if (req_here) begin
               cnt_d = '0;
            end else if (step_tick) begin
               if (cnt_q == DOOR_LAST) begin
                  state_d = IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end

         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // State registers plus the indicator outputs, which are derived from the
   // next state so they change in the same cycle as the state itself.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         dir_q       <= NONE;
         floor_q     <= FLOOR_MIN;
         cnt_q       <= '0;
         dir_up_q    <= 1'b0;
         dir_down_q  <= 1'b0;
         moving_q    <= 1'b0;
         door_open_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         dir_q       <= dir_d;
         floor_q     <= floor_d;
         cnt_q       <= cnt_d;
         dir_up_q    <= (state_d == MOVE) && (dir_d == UP);
         dir_down_q  <= (state_d == MOVE) && (dir_d == DOWN);
         moving_q    <= (state_d == MOVE);
         door_open_q <= (state_d == DOOR);
      end
   end

   assign cur_floor = floor_q;
   assign dir_up    = dir_up_q;
   assign dir_down  = dir_down_q;
   assign moving    = moving_q;
   assign door_open = door_open_q;
   assign pending   = pending_w;

`ifndef SYNTHESIS
   // A floor step must never carry the car past either end of the shaft.
   always @(posedge clk) begin
      if (rst && (state_q == MOVE) && step_tick && (cnt_q == MOVE_LAST))
         assert (((dir_q == UP) && (floor_q < TOP_FLOOR)) ||
                 ((dir_q == DOWN) && (floor_q > FLOOR_MIN)));
   end
`endif

endmodule

// File: tb/tb_elevator_car_ctrl.sv
// tb_elevator_car_ctrl
// Directed bench for elevator_car_ctrl. Each scenario pushes the expected
// (floor, pending) pair for every door opening it provokes; a monitor pops
// one entry per rising door_open and compares. Timing details are checked
// inline with checkOutput.
module tb_elevator_car_ctrl;

   logic       clk       = 1'b0;
   logic       rst       = 1'b1;
   logic       req_valid = 1'b0;
   logic [2:0] req_floor = 3'd0;
   logic       step_tick = 1'b0;
   logic [2:0] cur_floor;
   logic       dir_up, dir_down, moving, door_open;
   logic [4:0] pending;

   int compared   = 0;
   int mismatched = 0;

   typedef struct {
      string      name;
      logic [2:0] floor;
      logic [4:0] pend;
   } exp_t;

   exp_t exp_q[$];
   logic door_seen = 1'b0;

   elevator_car_ctrl #(
      .NUM_FLOORS (5),
      .MOVE_TICKS (2),
      .DOOR_TICKS (3)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_floor (req_floor),
      .step_tick (step_tick),
      .cur_floor (cur_floor),
      .dir_up    (dir_up),
      .dir_down  (dir_down),
      .moving    (moving),
      .door_open (door_open),
      .pending   (pending)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
      end
   endtask

   task automatic pushExpect(input string name, input logic [2:0] f, input logic [4:0] p);
      exp_t e;
      e.name  = name;
      e.floor = f;
      e.pend  = p;
      exp_q.push_back(e);
   endtask

   task automatic stepCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic [2:0] f, input logic with_tick);
      req_valid = 1'b1;
      req_floor = f;
      step_tick = with_tick;
      stepCycle();
      req_valid = 1'b0;
      step_tick = 1'b0;
   endtask

   task automatic giveTicks(input int n);
      repeat (n) begin
         step_tick = 1'b1;
         stepCycle();
         step_tick = 1'b0;
      end
   endtask

   // Scoreboard monitor: one expectation per door opening.
   always @(negedge clk) begin
      if (door_open === 1'b1 && door_seen !== 1'b1) begin
         if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL unexpected_door: actual floor=%0d required no door", cur_floor);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            checkOutput({e.name, "_floor"}, 32'(cur_floor), 32'(e.floor));
            checkOutput({e.name, "_pending"}, 32'(pending), 32'(e.pend));
         end
      end
      door_seen = door_open;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Power-on reset.
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_floor", 32'(cur_floor), 32'd1);
      checkOutput("rst_pending", 32'(pending), 32'd0);
      checkOutput("rst_door", 32'(door_open), 32'd0);
      checkOutput("rst_moving", 32'(moving), 32'd0);
      checkOutput("rst_dir", 32'({dir_up, dir_down}), 32'd0);
      rst = 1'b1;
      stepCycle();

      // Floor 1 -> 4.
      $display("[TB] scenario: floor 1 to 4");
      pushExpect("A4", 3'd4, 5'b00000);
      applyStimulus(3'd4, 1'b0);
      checkOutput("A_pending_set", 32'(pending), 32'b01000);
      checkOutput("A_not_yet_moving", 32'(moving), 32'd0);
      stepCycle();
      checkOutput("A_moving", 32'(moving), 32'd1);
      checkOutput("A_dir", 32'({dir_up, dir_down}), 32'b10);
      giveTicks(2);
      checkOutput("A_floor_t2", 32'(cur_floor), 32'd2);
      giveTicks(2);
      checkOutput("A_floor_t4", 32'(cur_floor), 32'd3);
      giveTicks(2);
      checkOutput("A_door_t6", 32'(door_open), 32'd1);
      checkOutput("A_dir_in_door", 32'({dir_up, dir_down}), 32'd0);
      giveTicks(2);
      checkOutput("A_door_dwell2", 32'(door_open), 32'd1);
      giveTicks(1);
      checkOutput("A_door_closed", 32'(door_open), 32'd0);

      // Reset while travelling from 4 towards 5.
      $display("[TB] scenario: reset mid-move");
      applyStimulus(3'd5, 1'b0);
      stepCycle();
      giveTicks(1);
      #3 rst = 1'b0;
      #2;
      checkOutput("R_floor", 32'(cur_floor), 32'd1);
      checkOutput("R_pending", 32'(pending), 32'd0);
      checkOutput("R_moving", 32'(moving), 32'd0);
      checkOutput("R_door", 32'(door_open), 32'd0);
      checkOutput("R_dir", 32'({dir_up, dir_down}), 32'd0);
      rst = 1'b1;
      stepCycle();

      // Floor 1 -> 5 with 3 added on the way.
      $display("[TB] scenario: pick up 3 on the way to 5");
      pushExpect("B3", 3'd3, 5'b10000);
      pushExpect("B5", 3'd5, 5'b00000);
      applyStimulus(3'd5, 1'b0);
      stepCycle();
      giveTicks(2);
      checkOutput("B_floor2", 32'(cur_floor), 32'd2);
      applyStimulus(3'd3, 1'b0);
      checkOutput("B_pending_both", 32'(pending), 32'b10100);
      giveTicks(2);
      giveTicks(3);
      checkOutput("B_idle_pending", 32'(pending), 32'b10000);
      stepCycle();
      checkOutput("B_resume_up", 32'({dir_up, dir_down, moving}), 32'b101);
      giveTicks(4);
      giveTicks(3);

      // Go to 3, head up to 5, add 1 on the way: serve 5, then reverse.
      $display("[TB] scenario: reverse after top request");
      pushExpect("C3", 3'd3, 5'b00000);
      applyStimulus(3'd3, 1'b0);
      stepCycle();
      checkOutput("C_dir_down", 32'({dir_up, dir_down}), 32'b01);
      giveTicks(4);
      giveTicks(3);
      pushExpect("C5", 3'd5, 5'b00001);
      pushExpect("C1", 3'd1, 5'b00000);
      applyStimulus(3'd5, 1'b0);
      stepCycle();
      checkOutput("C_dir_up", 32'({dir_up, dir_down}), 32'b10);
      giveTicks(1);
      applyStimulus(3'd1, 1'b0);
      checkOutput("C_pending", 32'(pending), 32'b10001);
      giveTicks(1);
      checkOutput("C_floor4", 32'(cur_floor), 32'd4);
      giveTicks(2);
      giveTicks(3);
      stepCycle();
      checkOutput("C_reversed", 32'({dir_up, dir_down}), 32'b01);
      giveTicks(8);
      giveTicks(3);

      // Request own floor in IDLE, then again during the dwell.
      $display("[TB] scenario: own-floor request and dwell restart");
      pushExpect("D1", 3'd1, 5'b00000);
      applyStimulus(3'd1, 1'b0);
      checkOutput("D_door_next", 32'(door_open), 32'd1);
      checkOutput("D_pending", 32'(pending), 32'd0);
      giveTicks(2);
      applyStimulus(3'd1, 1'b0);
      giveTicks(2);
      checkOutput("D_dwell_restarted", 32'(door_open), 32'd1);
      giveTicks(1);
      checkOutput("D_door_closed", 32'(door_open), 32'd0);

      // Invalid floors.
      $display("[TB] scenario: invalid floors");
      applyStimulus(3'd0, 1'b0);
      applyStimulus(3'd6, 1'b0);
      applyStimulus(3'd7, 1'b0);
      stepCycle();
      checkOutput("E_pending", 32'(pending), 32'd0);
      checkOutput("E_idle", 32'({moving, door_open}), 32'd0);
      checkOutput("E_floor", 32'(cur_floor), 32'd1);

      // Request 2 in the very cycle of the arrival tick at 2.
      $display("[TB] scenario: coincident request and arrival");
      pushExpect("F2", 3'd2, 5'b00100);
      pushExpect("F3", 3'd3, 5'b00000);
      applyStimulus(3'd3, 1'b0);
      stepCycle();
      giveTicks(1);
      applyStimulus(3'd2, 1'b1);
      checkOutput("F_floor", 32'(cur_floor), 32'd2);
      checkOutput("F_door", 32'(door_open), 32'd1);
      checkOutput("F_bit_clear", 32'(pending), 32'b00100);
      giveTicks(3);
      stepCycle();
      checkOutput("F_resume_up", 32'({dir_up, dir_down}), 32'b10);
      giveTicks(2);
      giveTicks(3);

      repeat (3) stepCycle();
      while (exp_q.size() != 0) begin
         exp_t e;
         e = exp_q.pop_front();
         compared++;
         mismatched++;
         $display("[TB] FAIL %s_missing: actual no door required door at floor %0d", e.name, e.floor);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
